// File: rtl/bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// with a single borrow flip-flop, a start/busy/done handshake and a parallel result.
module bit_serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             diff_bit,
    output logic             diff_valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    count_q, count_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic             diff_bit_q, diff_bit_d;
    logic             diff_valid_q, diff_valid_d;

    // Half-subtractor chained through the incoming borrow: returns {borrow, difference}.
    function automatic logic [1:0] sub_step(input logic a0, input logic b0, input logic br);
        logic d;
        logic bo;
        d  = a0 ^ b0 ^ br;
        bo = (~a0 & b0) | (~(a0 ^ b0) & br);
        return {bo, d};
    endfunction

    logic [1:0]     step;
    logic [WIDTH:0] res_ext;

    always_comb begin
        state_d      = state_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        res_d        = res_q;
        diff_d       = diff_q;
        count_d      = count_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        diff_bit_d   = 1'b0;
        diff_valid_d = 1'b0;
        step         = 2'b00;
        res_ext      = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // Bit 0 is computed at acceptance so the registered serial output
                    // carries it in the very first busy cycle.
                    step         = sub_step(a[0], b[0], 1'b0);
                    res_ext      = {step[0], {WIDTH{1'b0}}};
                    res_d        = res_ext[WIDTH:1];
                    sa_d         = a >> 1;
                    sb_d         = b >> 1;
                    borrow_d     = step[1];
                    count_d      = '0;
                    diff_bit_d   = step[0];
                    diff_valid_d = 1'b1;
                    diff_d       = '0;
                    borrow_out_d = 1'b0;
                    state_d      = StShift;
                end
            end
            StShift: begin
                if (count_q == CW'(WIDTH - 1)) begin
                    diff_d       = res_q;
                    borrow_out_d = borrow_q;
                    state_d      = StDone;
                end else begin
                    step         = sub_step(sa_q[0], sb_q[0], borrow_q);
                    res_ext      = {step[0], res_q};
                    res_d        = res_ext[WIDTH:1];
                    sa_d         = sa_q >> 1;
                    sb_d         = sb_q >> 1;
                    borrow_d     = step[1];
                    count_d      = count_q + 1'b1;
                    diff_bit_d   = step[0];
                    diff_valid_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sa_q         <= '0;
            sb_q         <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            count_q      <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            diff_bit_q   <= 1'b0;
            diff_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            count_q      <= count_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
            diff_bit_q   <= diff_bit_d;
            diff_valid_q <= diff_valid_d;
        end
    end

    assign busy       = (state_q == StShift);
    assign done       = (state_q == StDone);
    assign diff_bit   = diff_bit_q;
    assign diff_valid = diff_valid_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: doc/bit_serial_subtractor.md
Name: bit_serial_subtractor

Overview:
- Subtract-direction companion to the team's combinational half adder. Computes unsigned A - B one bit per clock, LSB first, using a single borrow flip-flop.
- Each difference bit is produced by half-subtractor logic chained through the stored borrow.
- Used wherever area matters more than latency, and as the serial datapath partner to the adder cells.
- Offers a start/busy/done handshake, a serial bit stream and a parallel result.

Parameters:
WIDTH, 4, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  single clock, rising-edge active
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; honoured only when idle
a  input  WIDTH  minuend; sampled on the accepted start
b  input  WIDTH  subtrahend; sampled on the accepted start
busy  output  1  high while an operation is in progress
diff_bit  output  1  current serial difference bit, LSB first
diff_valid  output  1  qualifies diff_bit
diff  output  WIDTH  parallel difference; valid when done=1 and held until the next accepted start
borrow_out  output  1  final borrow (1 means a < b); same validity as diff
done  output  1  one-cycle pulse at completion

Behaviour:
- Reset (sampled at a clk edge with rst=1):
  - state=IDLE; borrow register=0; bit counter=0; shift registers=0.
  - busy=0, diff_bit=0, diff_valid=0, diff=0, borrow_out=0, done=0.
  - rst has priority over every other input in the same cycle.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 latches a into sa and b into sb, clears borrow and count, and moves to SHIFT.
  - busy goes high on the following cycle.
  - start=0: remain in IDLE.
- SHIFT, each cycle:
  - a0=sa[0], b0=sb[0], br=borrow.
  - diff_bit = a0 ^ b0 ^ br; diff_valid=1.
  - borrow_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - sa and sb shift right by 1. The result register shifts right with diff_bit entering at the MSB, so after WIDTH shifts bit i holds difference bit i.
  - count increments. When count reaches WIDTH-1 in this cycle, the next state is DONE.
- DONE (exactly one cycle):
  - done=1, busy=0, diff_valid=0.
  - diff = completed result register; borrow_out = final borrow.
  - Next state is IDLE.
- Output timing: diff_bit, diff_valid, diff and borrow_out are registered outputs.
- Latency: with start accepted at edge 0:
  - diff_valid=1 for cycles 1..WIDTH, carrying bit k in cycle k+1.
  - done=1 in cycle WIDTH+1.
  - Total WIDTH+1 cycles from start to done; the next start can be accepted in cycle WIDTH+2.
- Arithmetic: diff = (a - b) mod 2^WIDTH; borrow_out = (a < b) as unsigned.
- start during SHIFT or DONE is ignored. No queuing; the operands in flight are unaffected.
- a and b are don't-care except at the accepted start edge. Changing them mid-operation has no effect.
- diff and borrow_out hold their values after done until the next accepted start, at which point both clear to 0.
- Reset mid-operation aborts immediately: IDLE next cycle, all outputs as in reset, no done pulse.
- WIDTH=1: one SHIFT cycle, then DONE.
- Bit counter width is clog2(WIDTH)+1; it must not wrap before WIDTH.

Test Plan:
1. WIDTH=4, a=5, b=3, single start:
   - diff_bit sequence 0,1,0,0 (LSB first) on cycles 1..4.
   - done in cycle 5 with diff=2, borrow_out=0.
2. a=3, b=5: serial bits 0,1,1,1; diff=14 (1110b), borrow_out=1.
3. Corner operands:
   - a=0, b=1 gives diff=15, borrow_out=1.
   - a=15, b=15 gives diff=0, borrow_out=0.
   - a=0, b=0 gives diff=0, borrow_out=0.
4. Start with a=9, b=4; pulse start again with a=1, b=1 in cycle 2:
   - Second start is ignored; result is diff=5, borrow_out=0.
   - busy is high cycles 1..4; exactly one done pulse.
5. Start with a=12, b=7; assert rst in cycle 2:
   - Next cycle all outputs are 0 and state is IDLE; no done pulse.
   - A fresh start with a=12, b=7 then yields diff=5, borrow_out=0.
6. Back-to-back: start in cycle 0 and in cycle WIDTH+2 (the first cycle after done):
   - Both are accepted.
   - diff holds the first result from done until the second start, then clears to 0.
